// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: recovers b = sum - a, LSB first, one bit per clock,
// with ready/valid handshakes and a flag for sums no pair of addends can produce.
module serial_subtractor #(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   sum,
  input  logic [WIDTH-1:0] a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] b,
  output logic             range_err
);

  localparam int            CW   = (WIDTH + 1 > 1) ? $clog2(WIDTH + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH:0]   s_sh_r, a_sh_r, res_r;
  logic [CW-1:0]    cnt_r;
  logic             br_r;
  logic             d_s, br_s;
  logic             accept_s, last_s, release_s;
  logic [WIDTH-1:0] b_r;
  logic             range_err_r, out_valid_r;

  // Next-state decode plus the single full-subtractor cell of the serial datapath
  always_comb begin
    state_s   = state_r;
    accept_s  = 1'b0;
    last_s    = 1'b0;
    release_s = 1'b0;
    d_s       = s_sh_r[0] ^ a_sh_r[0] ^ br_r;
    br_s      = (~s_sh_r[0] & a_sh_r[0]) | (~(s_sh_r[0] ^ a_sh_r[0]) & br_r);
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          accept_s = 1'b1;
          state_s  = RUN;
        end else begin
          state_s  = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == LAST) begin
          last_s  = 1'b1;
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          release_s = 1'b1;
          state_s   = IDLE;
        end else begin
          state_s   = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Shift registers, borrow and bit counter; counter holds at LAST so it never wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_sh_r <= '0;
      a_sh_r <= '0;
      res_r  <= '0;
      br_r   <= 1'b0;
      cnt_r  <= '0;
    end else if (accept_s) begin
      s_sh_r <= sum;
      a_sh_r <= {1'b0, a};
      res_r  <= '0;
      br_r   <= 1'b0;
      cnt_r  <= '0;
    end else if (state_r == RUN) begin
      s_sh_r <= {1'b0, s_sh_r[WIDTH:1]};
      a_sh_r <= {1'b0, a_sh_r[WIDTH:1]};
      res_r  <= {d_s, res_r[WIDTH:1]};
      br_r   <= br_s;
      if (!last_s) begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  // Result registers: on the last bit the top diff bit is d_s, the rest already sit in res_r
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_r         <= '0;
      range_err_r <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (last_s) begin
      b_r         <= res_r[WIDTH:1];
      range_err_r <= br_s | d_s;
      out_valid_r <= 1'b1;
    end else if (release_s) begin
      out_valid_r <= 1'b0;
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = out_valid_r;
  assign b         = b_r;
  assign range_err = range_err_r;

endmodule
